// File: rtl/demux_pkg.sv
// Shared definitions for the demux bank: mode encodings and the one-hot decode helper.
package demux_pkg;

   localparam logic [1:0] MODE_DIRECT = 2'b00;
   localparam logic [1:0] MODE_LATCH  = 2'b01;
   localparam logic [1:0] MODE_SCAN   = 2'b10;

   // Widest select the bank supports; decode works at this width and callers
   // cast the result down to their own output count.
   localparam int MAX_SEL_W = 4;
   localparam int MAX_OUT_N = 2 ** MAX_SEL_W;

   // One-hot (act=1) or one-cold (act=0) decode of addr.
   function automatic logic [MAX_OUT_N-1:0] decode(input logic [MAX_SEL_W-1:0] addr,
                                                   input logic                 act);
      logic [MAX_OUT_N-1:0] hot;
      hot = MAX_OUT_N'(1) << addr;
      return act ? hot : ~hot;
   endfunction

endpackage

// File: rtl/demux_bank_seq_if.sv
// Bus bundle between the demux bank and whatever drives it.
// Inputs are sampled on every rising clock edge; there is no handshake, every
// cycle is a transfer and y/scan_addr/scan_wrap are registered outputs.
interface demux_bank_seq_if #(
   parameter int CH    = 2,
   parameter int SEL_W = 2
);
   localparam int OUT_N = 2 ** SEL_W;

   logic [1:0]          mode;
   logic [CH-1:0]       en_n;
   logic [CH*SEL_W-1:0] sel;
   logic [CH-1:0]       ld;
   logic [CH*OUT_N-1:0] y;
   logic [SEL_W-1:0]    scan_addr;
   logic                scan_wrap;

   modport master (
      output mode, en_n, sel, ld,
      input  y, scan_addr, scan_wrap
   );

   modport slave (
      input  mode, en_n, sel, ld,
      output y, scan_addr, scan_wrap
   );
endinterface

// File: rtl/demux_dec_ch.sv
// One decoder channel: address latch, effective-address select and the
// registered decode output.
module demux_dec_ch
   import demux_pkg::*;
#(
   parameter int SEL_W      = 2,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            mode,
   input  logic                  en_n,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  ld,
   input  logic [SEL_W-1:0]      scan_addr,
   output logic [2**SEL_W-1:0]   y
);

   localparam int   OUT_N = 2 ** SEL_W;
   localparam logic ACT   = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
   localparam logic INACT = ~ACT;

   logic [SEL_W-1:0] lat_q;
   logic [SEL_W-1:0] eff;

   // Effective address; a load is transparent in its own cycle in latched mode.
   always_comb begin
      eff = sel;
      case (mode)
         MODE_LATCH: eff = ld ? sel : lat_q;
         MODE_SCAN:  eff = scan_addr;
         default:    eff = sel;
      endcase
   end

   // Address latch (loads in every mode, independent of enable) and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_q <= '0;
         y     <= {OUT_N{INACT}};
      end else begin
         if (ld) begin
            lat_q <= sel;
         end
         if (en_n) begin
            y <= {OUT_N{INACT}};
         end else begin
            y <= OUT_N'(decode(MAX_SEL_W'(eff), ACT));
         end
      end
   end

endmodule

// File: rtl/demux_bank_seq.sv
// Bank of CH registered 1-of-2^SEL_W decoders with a shared auto-scan counter.
module demux_bank_seq
   import demux_pkg::*;
#(
   parameter int CH         = 2,
   parameter int SEL_W      = 2,
   parameter int SCAN_DIV   = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   demux_bank_seq_if.slave bus
);

   localparam int OUT_N = 2 ** SEL_W;
   localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [PW-1:0]    PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] CNT_MAX   = '1;

   logic [PW-1:0]       presc_q;
   logic [SEL_W-1:0]    cnt_q;
   logic                wrap_q;
   logic                was_scan_q;
   logic                scan_mode;
   logic [CH*OUT_N-1:0] y_all;

   assign scan_mode = (bus.mode == MODE_SCAN);

   // Scan engine: prescaled counter, cleared outside scan and on scan entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         cnt_q      <= '0;
         wrap_q     <= 1'b0;
         was_scan_q <= 1'b0;
      end else begin
         was_scan_q <= scan_mode;
         if (!scan_mode || !was_scan_q) begin
            presc_q <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
         end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            cnt_q   <= cnt_q + SEL_W'(1);
            wrap_q  <= (cnt_q == CNT_MAX);
         end else begin
            presc_q <= presc_q + PW'(1);
            wrap_q  <= 1'b0;
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      demux_dec_ch #(
         .SEL_W      (SEL_W),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .mode      (bus.mode),
         .en_n      (bus.en_n[c]),
         .sel       (bus.sel[c*SEL_W +: SEL_W]),
         .ld        (bus.ld[c]),
         .scan_addr (cnt_q),
         .y         (y_all[c*OUT_N +: OUT_N])
      );
   end

   assign bus.y         = y_all;
   assign bus.scan_addr = cnt_q;
   assign bus.scan_wrap = wrap_q;

endmodule
